// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: branch-operation codes and the sequencing action
// chosen each cycle by the hazard/redirect controller.
package pipeline_pkg;

    localparam logic [4:0] BR_NEVER = 5'b00000;
    localparam logic [4:0] BR_BEQ   = 5'b01000;
    localparam logic [4:0] BR_BNE   = 5'b01001;
    localparam logic [4:0] BR_BLT   = 5'b01100;
    localparam logic [4:0] BR_BGE   = 5'b01101;
    localparam logic [4:0] BR_BLTU  = 5'b01110;
    localparam logic [4:0] BR_BGEU  = 5'b01111;

    // Unconditional jumps are any code with the top bit set (1xxxx).
    localparam logic [4:0] BR_ALWAYS = 5'b10000;

    typedef enum logic [1:0] {
        ActRun      = 2'd0,
        ActStall    = 2'd1,
        ActRedirect = 2'd2,
        ActFreeze   = 2'd3
    } action_e;

    function automatic logic is_jump(input logic [4:0] brop);
        return brop[4];
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and clear; clear beats increment.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_q <= '0;
        end else if (inc && (r_q != '1)) begin
            r_q <= r_q + W'(1);
        end
    end

    assign q = r_q;

endmodule

// File: rtl/hazard_redirect_ctrl.sv
// Pipeline sequencing controller: picks FREEZE/REDIRECT/STALL/RUN each cycle, drives PC and
// pipeline-register enables/flushes, and tracks per-stage valid bits and perf counters.
module hazard_redirect_ctrl
    import pipeline_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Freeze,
    input  logic             NextPCSrc,
    input  logic [4:0]       EXBrOp,
    input  logic             EXMemRead,
    input  logic [4:0]       EXrd,
    input  logic [4:0]       IDrs1,
    input  logic [4:0]       IDrs2,
    input  logic             CntClr,
    output logic             PCSel,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IFIDFlush,
    output logic             IDEXWrite,
    output logic             IDEXFlush,
    output logic [1:0]       LastAction,
    output logic [CNT_W-1:0] BranchCnt,
    output logic [CNT_W-1:0] TakenCnt,
    output logic [CNT_W-1:0] StallCnt
);

    logic    r_id_valid;
    logic    r_ex_valid;
    action_e r_last_action;

    action_e w_action;
    logic    w_load_use;
    logic    w_br_inc;
    logic    w_taken_inc;
    logic    w_stall_inc;

    assign w_load_use = r_id_valid && r_ex_valid && EXMemRead && (EXrd != 5'd0) &&
                        ((EXrd == IDrs1) || (EXrd == IDrs2));

    // Redirect is checked before stall so a wrong-path load-use hazard is dropped.
    always_comb begin
        if (Freeze) begin
            w_action = ActFreeze;
        end else if (r_ex_valid && NextPCSrc) begin
            w_action = ActRedirect;
        end else if (w_load_use) begin
            w_action = ActStall;
        end else begin
            w_action = ActRun;
        end
    end

    always_comb begin
        PCSel     = 1'b0;
        PCWrite   = 1'b0;
        IFIDWrite = 1'b0;
        IFIDFlush = 1'b0;
        IDEXWrite = 1'b0;
        IDEXFlush = 1'b0;
        if (rst) begin
            // Let the PC take its reset value while both pipeline registers load NOPs.
            PCWrite   = 1'b1;
            IFIDFlush = 1'b1;
            IDEXFlush = 1'b1;
        end else begin
            unique case (w_action)
                ActRun: begin
                    PCWrite   = 1'b1;
                    IFIDWrite = 1'b1;
                    IDEXWrite = 1'b1;
                end
                ActStall: begin
                    IDEXWrite = 1'b1;
                    IDEXFlush = 1'b1;
                end
                ActRedirect: begin
                    PCSel     = 1'b1;
                    PCWrite   = 1'b1;
                    IFIDWrite = 1'b1;
                    IDEXWrite = 1'b1;
                    IFIDFlush = 1'b1;
                    IDEXFlush = 1'b1;
                end
                ActFreeze: begin
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_id_valid    <= 1'b0;
            r_ex_valid    <= 1'b0;
            r_last_action <= ActRun;
        end else begin
            r_last_action <= w_action;
            unique case (w_action)
                ActRun: begin
                    r_ex_valid <= r_id_valid;
                    r_id_valid <= 1'b1;
                end
                ActStall: begin
                    r_ex_valid <= 1'b0;
                end
                ActRedirect: begin
                    r_id_valid <= 1'b0;
                    r_ex_valid <= 1'b0;
                end
                ActFreeze: begin
                end
                default: begin
                end
            endcase
        end
    end

    assign LastAction = r_last_action;

    // The action is FREEZE whenever Freeze is high, so these are already frozen out.
    assign w_br_inc    = (w_action != ActFreeze) && r_ex_valid && (EXBrOp != BR_NEVER);
    assign w_taken_inc = (w_action == ActRedirect);
    assign w_stall_inc = (w_action == ActStall);

    sat_counter #(.W(CNT_W)) u_branch_cnt (
        .clk (clk),
        .rst (rst),
        .clr (CntClr),
        .inc (w_br_inc),
        .q   (BranchCnt)
    );

    sat_counter #(.W(CNT_W)) u_taken_cnt (
        .clk (clk),
        .rst (rst),
        .clr (CntClr),
        .inc (w_taken_inc),
        .q   (TakenCnt)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .clr (CntClr),
        .inc (w_stall_inc),
        .q   (StallCnt)
    );

endmodule

// File: tb/tb_hazard_redirect_ctrl.sv
// Self-checking bench for hazard_redirect_ctrl: directed scenarios plus random traffic
// compared against a cycle-level behavioural model of the pipeline sequencing rules.
module tb_hazard_redirect_ctrl;

    localparam int CNT_W = 4;
    localparam int SAT   = 15;

    logic             clk = 1'b0;
    logic             rst;
    logic             Freeze;
    logic             NextPCSrc;
    logic [4:0]       EXBrOp;
    logic             EXMemRead;
    logic [4:0]       EXrd;
    logic [4:0]       IDrs1;
    logic [4:0]       IDrs2;
    logic             CntClr;
    logic             PCSel;
    logic             PCWrite;
    logic             IFIDWrite;
    logic             IFIDFlush;
    logic             IDEXWrite;
    logic             IDEXFlush;
    logic [1:0]       LastAction;
    logic [CNT_W-1:0] BranchCnt;
    logic [CNT_W-1:0] TakenCnt;
    logic [CNT_W-1:0] StallCnt;

    hazard_redirect_ctrl #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .Freeze     (Freeze),
        .NextPCSrc  (NextPCSrc),
        .EXBrOp     (EXBrOp),
        .EXMemRead  (EXMemRead),
        .EXrd       (EXrd),
        .IDrs1      (IDrs1),
        .IDrs2      (IDrs2),
        .CntClr     (CntClr),
        .PCSel      (PCSel),
        .PCWrite    (PCWrite),
        .IFIDWrite  (IFIDWrite),
        .IFIDFlush  (IFIDFlush),
        .IDEXWrite  (IDEXWrite),
        .IDEXFlush  (IDEXFlush),
        .LastAction (LastAction),
        .BranchCnt  (BranchCnt),
        .TakenCnt   (TakenCnt),
        .StallCnt   (StallCnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: instruction occupancy of ID and EX, plus plain integer counters.
    bit m_id, m_ex;
    int m_last, m_br, m_tk, m_st;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v + 1 > SAT) ? SAT : v + 1;
    endfunction

    task automatic idle_inputs();
        rst = 0; Freeze = 0; NextPCSrc = 0; EXBrOp = 5'b00000; EXMemRead = 0;
        EXrd = 0; IDrs1 = 0; IDrs2 = 0; CntClr = 0;
    endtask

    // Called ~1 time unit after a rising edge with inputs already applied.
    task automatic do_cycle();
        int act;
        bit e_pcsel, e_pcw, e_ifw, e_iff, e_idw, e_idf;
        act = 0;
        if (rst) begin
            e_pcsel = 0; e_pcw = 1; e_ifw = 0; e_idw = 0; e_iff = 1; e_idf = 1;
        end else begin
            if (Freeze) act = 3;
            else if (m_ex && NextPCSrc) act = 2;
            else if (m_id && m_ex && EXMemRead && EXrd != 0 && (EXrd == IDrs1 || EXrd == IDrs2))
                act = 1;
            else act = 0;
            e_pcsel = (act == 2);
            e_pcw   = (act == 0 || act == 2);
            e_ifw   = e_pcw;
            e_idw   = (act != 3);
            e_iff   = (act == 2);
            e_idf   = (act == 1 || act == 2);
        end
        #2;
        check_eq("PCSel", 32'(PCSel), 32'(e_pcsel));
        check_eq("PCWrite", 32'(PCWrite), 32'(e_pcw));
        check_eq("IFIDWrite", 32'(IFIDWrite), 32'(e_ifw));
        check_eq("IFIDFlush", 32'(IFIDFlush), 32'(e_iff));
        check_eq("IDEXWrite", 32'(IDEXWrite), 32'(e_idw));
        check_eq("IDEXFlush", 32'(IDEXFlush), 32'(e_idf));
        @(posedge clk);
        #1;
        if (rst) begin
            m_id = 0; m_ex = 0; m_last = 0; m_br = 0; m_tk = 0; m_st = 0;
        end else begin
            m_last = act;
            if (CntClr) begin
                m_br = 0; m_tk = 0; m_st = 0;
            end else if (act != 3) begin
                if (m_ex && EXBrOp != 5'b00000) m_br = sat_inc(m_br);
                if (act == 2) m_tk = sat_inc(m_tk);
                if (act == 1) m_st = sat_inc(m_st);
            end
            case (act)
                0: begin m_ex = m_id; m_id = 1; end
                1: m_ex = 0;
                2: begin m_id = 0; m_ex = 0; end
                default: ;
            endcase
        end
        check_eq("LastAction", 32'(LastAction), 32'(m_last));
        check_eq("BranchCnt", 32'(BranchCnt), 32'(m_br));
        check_eq("TakenCnt", 32'(TakenCnt), 32'(m_tk));
        check_eq("StallCnt", 32'(StallCnt), 32'(m_st));
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) do_cycle();
    endtask

    initial begin
        logic [4:0] brops [8];
        brops[0] = 5'b00000; brops[1] = 5'b01000; brops[2] = 5'b01001; brops[3] = 5'b01100;
        brops[4] = 5'b01101; brops[5] = 5'b01110; brops[6] = 5'b01111; brops[7] = 5'b10101;

        idle_inputs();
        #1;
        rst = 1;
        cycles(2);
        rst = 0;
        // First cycle after reset: NextPCSrc must be ignored since EX holds nothing.
        NextPCSrc = 1;
        do_cycle();
        NextPCSrc = 0;
        check_eq("first_cycle_run", 32'(LastAction), 32'd0);
        cycles(3);

        // Taken branch, then a stray NextPCSrc on the bubble.
        EXBrOp = 5'b01000; NextPCSrc = 1;
        do_cycle();
        check_eq("br_taken_branchcnt", 32'(BranchCnt), 32'd1);
        check_eq("br_taken_takencnt", 32'(TakenCnt), 32'd1);
        do_cycle();
        check_eq("bubble_ignores_npc", 32'(TakenCnt), 32'd1);
        idle_inputs();
        cycles(2);

        // Load-use on rs2, then the same with EXrd=0.
        EXMemRead = 1; EXrd = 5; IDrs2 = 5;
        do_cycle();
        check_eq("loaduse_action", 32'(LastAction), 32'd1);
        do_cycle();
        check_eq("after_stall_run", 32'(LastAction), 32'd0);
        check_eq("stallcnt_one", 32'(StallCnt), 32'd1);
        EXrd = 0; IDrs2 = 0;
        cycles(2);
        check_eq("x0_no_stall", 32'(StallCnt), 32'd1);

        // Redirect and load-use together.
        EXrd = 5; IDrs1 = 5; NextPCSrc = 1; EXBrOp = 5'b01001;
        do_cycle();
        check_eq("redirect_beats_stall", 32'(LastAction), 32'd2);
        check_eq("stall_unchanged", 32'(StallCnt), 32'd1);
        idle_inputs();
        cycles(2);

        // Freeze over a pending jump.
        Freeze = 1; NextPCSrc = 1; EXBrOp = 5'b10000;
        cycles(3);
        check_eq("freeze_taken_held", 32'(TakenCnt), 32'd2);
        Freeze = 0;
        do_cycle();
        check_eq("redirect_after_freeze", 32'(LastAction), 32'd2);
        idle_inputs();
        cycles(2);

        // 17 taken branches (one every 3 cycles) saturate the 4-bit counter.
        EXBrOp = 5'b01000; NextPCSrc = 1;
        cycles(51);
        check_eq("taken_saturates", 32'(TakenCnt), 32'd15);
        CntClr = 1;
        do_cycle();
        check_eq("clear_wins", 32'(TakenCnt), 32'd0);
        idle_inputs();
        cycles(2);

        // Reset in the middle of a stall.
        EXMemRead = 1; EXrd = 7; IDrs1 = 7;
        do_cycle();
        rst = 1;
        do_cycle();
        check_eq("rst_clears_stallcnt", 32'(StallCnt), 32'd0);
        rst = 0; NextPCSrc = 1;
        do_cycle();
        check_eq("rst_clears_valid", 32'(LastAction), 32'd0);
        idle_inputs();

        for (int i = 0; i < 600; i++) begin
            rst       = ($urandom_range(0, 59) == 0);
            Freeze    = ($urandom_range(0, 5) == 0);
            NextPCSrc = ($urandom_range(0, 2) == 0);
            EXBrOp    = brops[$urandom_range(0, 7)];
            EXMemRead = $urandom_range(0, 1) != 0;
            EXrd      = 5'($urandom_range(0, 4));
            IDrs1     = 5'($urandom_range(0, 4));
            IDrs2     = 5'($urandom_range(0, 4));
            CntClr    = !Freeze && ($urandom_range(0, 29) == 0);
            do_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_redirect_ctrl.md
# hazard_redirect_ctrl

Pipeline sequencing controller for the segmented RISC-V core. It consumes the Branch_Unit's EX-stage decision (NextPCSrc) and the load-use hazard information, and drives PC selection, pipeline-register write enables and flushes. It tracks per-stage valid bits so that wrong-path or bubble instructions never redirect or stall the pipe. It also keeps saturating performance counters for branches, taken redirects and stall cycles.

## Interface
Parameters:
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- Freeze  in  1  global hold (memory busy); highest priority after rst.
- NextPCSrc  in  1  Branch_Unit output for the EX-stage instruction.
- EXBrOp  in  5  BrOp of the EX-stage instruction (00000 = not a branch).
- EXMemRead  in  1  EX-stage instruction is a load.
- EXrd  in  5  EX-stage destination register.
- IDrs1, IDrs2  in  5 each  ID-stage source registers.
- CntClr  in  1  synchronous clear of all counters.
- PCSel  out  1  1 selects the branch/jump target, 0 selects PC+4.
- PCWrite  out  1  PC register enable.
- IFIDWrite  out  1  IF/ID register enable.
- IFIDFlush  out  1  IF/ID register loads a NOP.
- IDEXWrite  out  1  ID/EX register enable.
- IDEXFlush  out  1  ID/EX register loads a NOP.
- LastAction  out  2  registered copy of the previous cycle's action (debug).
- BranchCnt, TakenCnt, StallCnt  out  CNT_W each  performance counters.

## Operation
- Internal state: IDValid and EXValid bits, LastAction register, three counters.
- Each cycle, the controller picks one action, in this priority order:
  - FREEZE (Freeze=1): PCWrite=IFIDWrite=IDEXWrite=0 and no flush. Valid bits are held. NextPCSrc and the hazard inputs are ignored.
  - REDIRECT (EXValid & NextPCSrc): PCSel=1, PCWrite=IFIDWrite=IDEXWrite=1, IFIDFlush=IDEXFlush=1. Next IDValid=0, EXValid=0.
  - STALL (load-use: IDValid & EXValid & EXMemRead & EXrd≠0 & (EXrd==IDrs1 | EXrd==IDrs2)): PCWrite=IFIDWrite=0, IDEXWrite=1, IDEXFlush=1. Next EXValid=0; IDValid is held.
  - RUN: PCSel=0 and all write enables 1, with no flush. Next EXValid=IDValid, IDValid=1.
- REDIRECT outranks STALL: a wrong-path load-use hazard is discarded.
- Action encoding: RUN=0, STALL=1, REDIRECT=2, FREEZE=3. LastAction takes the current action each cycle.
- Counters are not touched during FREEZE.
  - BranchCnt increments when EXValid & EXBrOp≠00000.
  - TakenCnt increments on REDIRECT.
  - StallCnt increments on STALL.
  - All counters saturate at all-ones and do not wrap.
  - CntClr zeroes them; a simultaneous increment is lost (clear wins).
- Jumps have BrOp 1xxxx, so NextPCSrc=1 and they count as both branch and taken.

## Timing
- Control outputs are combinational from the current inputs and state. Next state registers on the next clk edge.
- A redirect costs 2 bubble cycles. IDValid returns to 1 two edges after the REDIRECT cycle, and EXValid one edge later.
- A load-use stall costs exactly 1 cycle. The stalling instruction re-evaluates the next cycle with EXValid=0, so it proceeds.
- Behaviour while rst=1:
  - PCWrite=1 and PCSel=0, so the PC can load its reset value.
  - IFIDFlush=IDEXFlush=1; all other enables are 0.
  - On the edge: IDValid=EXValid=0, LastAction=RUN, all counters 0.
- First cycle after reset: the action is RUN. A NextPCSrc of 1 is ignored because EXValid=0.
- If Freeze overlaps a pending taken branch, the branch is held. REDIRECT fires on the first cycle with Freeze=0.

## Structure
- Shared package pipeline_pkg holds:
  - the BrOp constants (NEVER=00000, BEQ=01000, BNE=01001, BLT=01100, BGE=01101, BLTU=01110, BGEU=01111, ALWAYS=1xxxx);
  - the action enum (RUN/STALL/REDIRECT/FREEZE).
- Branch_Unit imports the same BrOp constants.
- One sub-module, sat_counter (parameter W; ports clk, rst, clr, inc, q). It is instantiated three times.

## Test plan
- Reset, then RUN with no hazards. After edge 1: IDValid=1. After edge 2: EXValid=1. Outputs stay at all enables 1, PCSel=0, no flush.
- Taken branch (EXValid=1, EXBrOp=01000, NextPCSrc=1):
  - In that cycle: PCSel=1 and both flushes are 1.
  - BranchCnt=1 and TakenCnt=1 after the edge.
  - The next cycle's NextPCSrc=1 is ignored because EXValid=0.
- Load-use (EXMemRead=1, EXrd=5, IDrs2=5):
  - One cycle with PCWrite=IFIDWrite=0 and IDEXFlush=1.
  - The next cycle is RUN, and StallCnt=1.
  - With EXrd=0 the same stimulus gives no stall.
- Taken branch and load-use in the same cycle: the action is REDIRECT and StallCnt is unchanged.
- Freeze=1 for 3 cycles with NextPCSrc=1:
  - All enables are 0 and the counters are unchanged.
  - On the first Freeze=0 cycle, REDIRECT fires.
- Counter saturation and clear (CNT_W=4):
  - 17 taken branches give TakenCnt=15.
  - CntClr together with a taken branch gives TakenCnt=0.
  - rst in the middle of a stall clears both valid bits and all counters.
